// File: rtl/byte_bus_arbiter_pkg.sv
// Shared types and constants for the byte bus arbiter.
package byte_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_IOWAIT = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // IO space is selected by address bits 17:16.
  localparam logic [31:0] IO_MASK = 32'h0003_0000;
  localparam logic [1:0]  IO_SEL  = 2'b11;

  // Number of bus bytes for a request size; 3 behaves like a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/byte_bus_arbiter_packer.sv
// Little-endian byte-to-word assembler. The output already includes the
// byte being captured this cycle, so a done pulse can accompany the last byte.
module byte_word_packer
  import byte_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_cap,
  input  logic [1:0]  i_idx,
  input  logic [7:0]  i_din,
  input  logic [2:0]  i_nbytes,
  output logic [31:0] o_word
);

  logic [31:0] r_word;
  logic [31:0] w_view;

  // Store captured bytes; cleared at the start of every request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_word <= 32'd0;
    end else if (i_cap) begin
      r_word[{i_idx, 3'b000} +: 8] <= i_din;
    end
  end

  // Merge the in-flight byte and zero bytes beyond the request size.
  always_comb begin
    w_view = r_word;
    if (i_cap) w_view[{i_idx, 3'b000} +: 8] = i_din;
    o_word = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < i_nbytes) o_word[8*k +: 8] = w_view[8*k +: 8];
    end
  end

endmodule

// File: rtl/byte_bus_arbiter.sv
// Shares the 8-bit memory/IO bus between the fetch port and the data port.
// Requests are word-level (req held until done); the bus side is one byte per
// cycle. Read data returns one cycle after its address, so a capture pointer
// trails the issue pointer and runs even while rdy is low.
module byte_bus_arbiter
  import byte_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IO_GAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  output logic              busy
);

  localparam int GAP_W = (IO_GAP > 1) ? $clog2(IO_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IO_GAP - 1);

  state_t              r_state, w_next;
  logic                r_owner_d;   // 1 = data port owns the transfer
  logic [2:0]          r_n;         // bytes in this transfer
  logic [2:0]          r_i;         // issue / write pointer
  logic [2:0]          r_c;         // read capture pointer
  logic                r_cap_pend;  // a read was issued last cycle
  logic                r_io_seen;   // an IO-space byte was written
  logic [GAP_W-1:0]    r_gap;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [ADDR_W-1:0]   r_last_a;

  logic [ADDR_W-1:0]   w_byte_addr;
  logic                w_byte_io;
  logic                w_grant_d, w_grant_if, w_grant;
  logic                w_rd_issue, w_rd_last;
  logic                w_wr_stall, w_wr_fire, w_wr_last;
  logic                w_gap_needed;
  logic [31:0]         w_word;

  assign w_byte_addr  = r_addr + ADDR_W'(r_i);
  assign w_byte_io    = ((32'(w_byte_addr) & IO_MASK) == {14'd0, IO_SEL, 16'd0});

  // Data port wins ties; nothing is granted while the bus is paused.
  assign w_grant_d    = (r_state == ST_IDLE) && rdy && d_req;
  assign w_grant_if   = (r_state == ST_IDLE) && rdy && !d_req && if_req;
  assign w_grant      = w_grant_d || w_grant_if;

  assign w_rd_issue   = (r_state == ST_RD) && rdy && (r_i < r_n);
  assign w_rd_last    = r_cap_pend && (r_c == r_n - 3'd1);

  assign w_wr_stall   = w_byte_io && io_buffer_full;
  assign w_wr_fire    = ((r_state == ST_WR) || (r_state == ST_IOWAIT)) && rdy && !w_wr_stall;
  assign w_wr_last    = w_wr_fire && (r_i == r_n - 3'd1);
  assign w_gap_needed = (IO_GAP > 0) && (r_io_seen || w_byte_io);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic. The final read capture completes the transfer even in
  // a paused cycle, since the capture itself does not depend on rdy.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d)       w_next = d_we ? ST_WR : ST_RD;
        else if (w_grant_if) w_next = ST_RD;
      end
      ST_RD: begin
        if (w_rd_last) w_next = ST_IDLE;
      end
      ST_WR, ST_IOWAIT: begin
        if (rdy) begin
          if (w_wr_stall)     w_next = ST_IOWAIT;
          else if (w_wr_last) w_next = w_gap_needed ? ST_GAP : ST_IDLE;
          else                w_next = ST_WR;
        end
      end
      ST_GAP: begin
        if (rdy && (r_gap == GAP_LAST)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, byte pointers and the held bus address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_d  <= 1'b0;
      r_n        <= 3'd0;
      r_i        <= 3'd0;
      r_c        <= 3'd0;
      r_cap_pend <= 1'b0;
      r_io_seen  <= 1'b0;
      r_gap      <= '0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_last_a   <= '0;
    end else begin
      r_cap_pend <= w_rd_issue;
      if (w_rd_issue || w_wr_fire) r_last_a <= w_byte_addr;
      if (w_grant) begin
        r_owner_d <= w_grant_d;
        r_n       <= w_grant_d ? size_bytes(d_size) : 3'd4;
        r_addr    <= w_grant_d ? d_addr : if_addr;
        r_wdata   <= d_wdata;
        r_i       <= 3'd0;
        r_c       <= 3'd0;
        r_io_seen <= 1'b0;
        r_gap     <= '0;
      end else begin
        if (w_rd_issue || w_wr_fire) r_i <= r_i + 3'd1;
        if (w_wr_fire && w_byte_io)  r_io_seen <= 1'b1;
        if (r_cap_pend)              r_c <= r_c + 3'd1;
        if ((r_state == ST_GAP) && rdy) r_gap <= r_gap + 1'b1;
      end
    end
  end

  byte_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_grant),
    .i_cap    (r_cap_pend),
    .i_idx    (r_c[1:0]),
    .i_din    (mem_din),
    .i_nbytes (r_n),
    .o_word   (w_word)
  );

  assign mem_wr   = w_wr_fire;
  assign mem_a    = (w_rd_issue || w_wr_fire) ? w_byte_addr : r_last_a;
  assign mem_dout = w_wr_fire ? r_wdata[{r_i[1:0], 3'b000} +: 8] : 8'd0;
  assign if_done  = w_rd_last && !r_owner_d;
  assign d_done   = (w_rd_last && r_owner_d) || w_wr_last;
  assign if_data  = w_word;
  assign d_rdata  = w_word;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_byte_bus_arbiter.sv
// Bench for byte_bus_arbiter: directed scenarios plus a randomized run checked
// against a byte-addressed reference memory and an expected-write queue.
module tb_byte_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        d_req, d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  logic [39:0] exp_q[$];

  logic [7:0] bus_ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  byte_bus_arbiter #(.ADDR_W(32), .IO_GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .busy(busy)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    if (bus_ram.exists(a)) return bus_ram[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  // Bus target: one-cycle read latency, writes land at the clock edge.
  always @(posedge clk) begin
    if (mem_wr) bus_ram[mem_a] = mem_dout;
    mem_din <= bus_rd(mem_a);
  end

  // Write scoreboard for the randomized run.
  always @(posedge clk) begin
    if (mon_en && rst_n && mem_wr) begin
      logic [39:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected got a=%h d=%h exp none", mem_a, mem_dout);
      end else begin
        e = exp_q.pop_front();
        if ({mem_a, mem_dout} !== e) begin
          n_fail++;
          $display("FAIL wr_byte got a=%h d=%h exp a=%h d=%h", mem_a, mem_dout, e[39:8], e[7:0]);
        end
      end
      n_checks++;
      if (mem_a[17:16] == 2'b11 && io_buffer_full) begin
        n_fail++;
        $display("FAIL io_write_while_full got mem_wr=1 exp 0 a=%h", mem_a);
      end
    end
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    io_buffer_full = 0; rdy = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    repeat (3) tick();
    #1;
    n_checks++; if (mem_wr !== 1'b0)   begin n_fail++; $display("FAIL rst_mem_wr got %b exp 0", mem_wr); end
    n_checks++; if (mem_a !== 32'd0)   begin n_fail++; $display("FAIL rst_mem_a got %h exp 0", mem_a); end
    n_checks++; if (mem_dout !== 8'd0) begin n_fail++; $display("FAIL rst_mem_dout got %h exp 0", mem_dout); end
    n_checks++; if ({if_done, d_done} !== 2'b00) begin n_fail++; $display("FAIL rst_done got %b exp 00", {if_done, d_done}); end
    n_checks++; if (if_data !== 32'd0) begin n_fail++; $display("FAIL rst_if_data got %h exp 0", if_data); end
    n_checks++; if (d_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_d_rdata got %h exp 0", d_rdata); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    rst_n = 1;
    repeat (2) tick();
  endtask

  task automatic test_fetch();
    bus_ram[32'h100] = 8'h13; bus_ram[32'h101] = 8'h00;
    bus_ram[32'h102] = 8'h50; bus_ram[32'h103] = 8'h00;
    tick(); if_req = 1; if_addr = 32'h100; #1;
    for (int k = 1; k <= 4; k++) begin
      tick(); #1;
      n_checks++; if (mem_a !== 32'h100 + k - 1) begin n_fail++; $display("FAIL fetch_addr c%0d got %h exp %h", k, mem_a, 32'h100 + k - 1); end
      n_checks++; if ({mem_wr, if_done} !== 2'b00) begin n_fail++; $display("FAIL fetch_wr_done c%0d got %b exp 00", k, {mem_wr, if_done}); end
    end
    tick(); #1;
    n_checks++; if (if_done !== 1'b1) begin n_fail++; $display("FAIL fetch_done got %b exp 1", if_done); end
    n_checks++; if (if_data !== 32'h00500013) begin n_fail++; $display("FAIL fetch_data got %h exp 00500013", if_data); end
    tick(); if_req = 0; #1;
    n_checks++; if ({if_done, busy} !== 2'b00) begin n_fail++; $display("FAIL fetch_after got done,busy=%b exp 00", {if_done, busy}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    int t;
    w = 32'hDEADBEEF;
    tick(); d_req = 1; d_we = 1; d_size = 2; d_addr = 32'h200; d_wdata = w; if_req = 1; if_addr = 32'h100; #1;
    for (int k = 1; k <= 4; k++) begin
      tick(); #1;
      n_checks++; if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL st_wr c%0d got %b exp 1", k, mem_wr); end
      n_checks++; if (mem_a !== 32'h200 + k - 1) begin n_fail++; $display("FAIL st_addr c%0d got %h exp %h", k, mem_a, 32'h200 + k - 1); end
      n_checks++; if (mem_dout !== w[8*(k-1) +: 8]) begin n_fail++; $display("FAIL st_byte c%0d got %h exp %h", k, mem_dout, w[8*(k-1) +: 8]); end
      n_checks++; if (d_done !== (k == 4)) begin n_fail++; $display("FAIL st_done c%0d got %b exp %b", k, d_done, (k == 4)); end
    end
    tick(); d_req = 0; d_we = 0; #1;
    n_checks++; if ({busy, mem_wr} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle got busy,wr=%b exp 00", {busy, mem_wr}); end
    tick(); #1;
    n_checks++; if ({busy, mem_wr} !== 2'b10) begin n_fail++; $display("FAIL b2b_fetch_grant got busy,wr=%b exp 10", {busy, mem_wr}); end
    n_checks++; if (mem_a !== 32'h100) begin n_fail++; $display("FAIL b2b_fetch_addr got %h exp 100", mem_a); end
    for (t = 0; t < 20 && if_done !== 1'b1; t++) tick();
    n_checks++; if (if_done !== 1'b1) begin n_fail++; $display("FAIL b2b_fetch_timeout got %b exp 1", if_done); end
    n_checks++; if (if_data !== 32'h00500013) begin n_fail++; $display("FAIL b2b_fetch_data got %h exp 00500013", if_data); end
    tick(); if_req = 0; tick();
  endtask

  task automatic test_io_store();
    int t;
    tick(); d_req = 1; d_we = 1; d_size = 0; d_addr = 32'h30000; d_wdata = 32'h41; #1;
    for (int k = 1; k <= 3; k++) begin
      tick(); io_buffer_full = 1; #1;
      n_checks++; if ({mem_wr, busy, d_done} !== 3'b010) begin n_fail++; $display("FAIL io_stall c%0d got wr,busy,done=%b exp 010", k, {mem_wr, busy, d_done}); end
    end
    tick(); io_buffer_full = 0; #1;
    n_checks++; if ({mem_wr, d_done} !== 2'b11) begin n_fail++; $display("FAIL io_write got wr,done=%b exp 11", {mem_wr, d_done}); end
    n_checks++; if ({mem_a, mem_dout} !== {32'h30000, 8'h41}) begin n_fail++; $display("FAIL io_write_bus got %h/%h exp 30000/41", mem_a, mem_dout); end
    tick(); d_req = 0; d_we = 0; if_req = 1; if_addr = 32'h100; #1;
    n_checks++; if ({busy, mem_wr} !== 2'b10) begin n_fail++; $display("FAIL io_gap got busy,wr=%b exp 10", {busy, mem_wr}); end
    tick(); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL io_gap_end got busy=%b exp 0", busy); end
    tick(); #1;
    n_checks++; if ({busy, mem_a} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL io_next_grant got busy=%b a=%h exp 1/100", busy, mem_a); end
    for (t = 0; t < 20 && if_done !== 1'b1; t++) tick();
    n_checks++; if (if_done !== 1'b1) begin n_fail++; $display("FAIL io_fetch_timeout got %b exp 1", if_done); end
    tick(); if_req = 0; tick();
  endtask

  task automatic test_half_load();
    bus_ram[32'h1FFFF] = 8'h34; bus_ram[32'h20000] = 8'h12;
    tick(); d_req = 1; d_we = 0; d_size = 1; d_addr = 32'h1FFFF; #1;
    tick(); #1;
    n_checks++; if ({mem_wr, mem_a} !== {1'b0, 32'h1FFFF}) begin n_fail++; $display("FAIL half_addr0 got wr=%b a=%h exp 0/1ffff", mem_wr, mem_a); end
    tick(); #1;
    n_checks++; if ({mem_wr, mem_a} !== {1'b0, 32'h20000}) begin n_fail++; $display("FAIL half_addr1 got wr=%b a=%h exp 0/20000", mem_wr, mem_a); end
    n_checks++; if (d_done !== 1'b0) begin n_fail++; $display("FAIL half_early_done got %b exp 0", d_done); end
    tick(); #1;
    n_checks++; if (d_done !== 1'b1) begin n_fail++; $display("FAIL half_done got %b exp 1", d_done); end
    n_checks++; if (d_rdata !== 32'h00001234) begin n_fail++; $display("FAIL half_data got %h exp 00001234", d_rdata); end
    tick(); d_req = 0; #1;
    n_checks++; if (d_done !== 1'b0) begin n_fail++; $display("FAIL half_pulse got %b exp 0", d_done); end
  endtask

  task automatic test_rdy_pause();
    bus_ram[32'h400] = 8'h11; bus_ram[32'h401] = 8'h22;
    bus_ram[32'h402] = 8'h33; bus_ram[32'h403] = 8'h44;
    tick(); if_req = 1; if_addr = 32'h400; #1;
    tick(); #1;
    n_checks++; if (mem_a !== 32'h400) begin n_fail++; $display("FAIL pause_c1 got %h exp 400", mem_a); end
    tick(); rdy = 0; #1;
    n_checks++; if ({mem_wr, if_done, busy} !== 3'b001) begin n_fail++; $display("FAIL pause_c2 got wr,done,busy=%b exp 001", {mem_wr, if_done, busy}); end
    for (int k = 3; k <= 5; k++) begin
      tick(); rdy = 1; #1;
      n_checks++; if (mem_a !== 32'h400 + k - 2) begin n_fail++; $display("FAIL pause_addr c%0d got %h exp %h", k, mem_a, 32'h400 + k - 2); end
      n_checks++; if (if_done !== 1'b0) begin n_fail++; $display("FAIL pause_early_done c%0d got %b exp 0", k, if_done); end
    end
    tick(); #1;
    n_checks++; if (if_done !== 1'b1) begin n_fail++; $display("FAIL pause_done got %b exp 1", if_done); end
    n_checks++; if (if_data !== 32'h44332211) begin n_fail++; $display("FAIL pause_data got %h exp 44332211", if_data); end
    tick(); if_req = 0; tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    w = 32'hCAFEF00D;
    tick(); d_req = 1; d_we = 1; d_size = 2; d_addr = 32'h500; d_wdata = w; #1;
    tick(); #1;
    n_checks++; if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL rmid_c1 got wr=%b exp 1", mem_wr); end
    tick(); rst_n = 0; #1;
    n_checks++; if ({mem_wr, d_done, busy} !== 3'b000) begin n_fail++; $display("FAIL rmid_abort got wr,done,busy=%b exp 000", {mem_wr, d_done, busy}); end
    n_checks++; if (mem_a !== 32'd0) begin n_fail++; $display("FAIL rmid_mem_a got %h exp 0", mem_a); end
    tick(); rst_n = 1; d_req = 0; #1;
    n_checks++; if ({d_done, busy} !== 2'b00) begin n_fail++; $display("FAIL rmid_release got done,busy=%b exp 00", {d_done, busy}); end
    tick(); d_req = 1; #1;
    for (int k = 1; k <= 4; k++) begin
      tick(); #1;
      n_checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h500 + 32'(k - 1), w[8*(k-1) +: 8]}) begin
        n_fail++; $display("FAIL rmid_reissue c%0d got wr=%b a=%h d=%h", k, mem_wr, mem_a, mem_dout);
      end
      n_checks++; if (d_done !== (k == 4)) begin n_fail++; $display("FAIL rmid_done c%0d got %b exp %b", k, d_done, (k == 4)); end
    end
    tick(); d_req = 0; d_we = 0; #1;
    n_checks++; if (bus_rd(32'h503) !== 8'hCA) begin n_fail++; $display("FAIL rmid_ram got %h exp ca", bus_rd(32'h503)); end
    tick();
  endtask

  task automatic test_random();
    int kind, n, r, cyc;
    bit done_seen;
    logic [1:0]  sz;
    logic [31:0] addr, wdata, exp_word, got, a;
    mon_en = 1;
    for (int t = 0; t < 48; t++) begin
      kind  = $urandom_range(0, 2);
      sz    = 2'($urandom_range(0, 3));
      wdata = $urandom;
      r     = $urandom_range(0, 9);
      if (r < 6)      addr = 32'h1000 + $urandom_range(0, 31);
      else if (r < 8) addr = 32'h30100 + $urandom_range(0, 7);
      else            addr = 32'hFFFFFFFC + $urandom_range(0, 3);
      n = (kind == 0 || sz == 2'd2 || sz == 2'd3) ? 4 : (sz == 2'd1 ? 2 : 1);
      exp_word = 32'd0;
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        if (kind == 2) begin
          exp_q.push_back({a, wdata[8*k +: 8]});
          ref_mem[a] = wdata[8*k +: 8];
        end else begin
          exp_word[8*k +: 8] = ref_rd(a);
        end
      end
      tick();
      if (kind == 0) begin if_req = 1; if_addr = addr; end
      else begin d_req = 1; d_we = (kind == 2); d_size = sz; d_addr = addr; d_wdata = wdata; end
      rdy = ($urandom_range(0, 3) != 0);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      #1;
      done_seen = 0;
      got = 32'd0;
      for (cyc = 0; cyc < 200 && !done_seen; cyc++) begin
        n_checks++;
        if ((kind == 0 ? d_done : if_done) !== 1'b0) begin n_fail++; $display("FAIL rnd_stray_done t%0d got 1 exp 0", t); end
        if ((kind == 0 ? if_done : d_done) === 1'b1) begin
          done_seen = 1;
          got = (kind == 0) ? if_data : d_rdata;
        end else begin
          tick();
          rdy = ($urandom_range(0, 3) != 0);
          io_buffer_full = ($urandom_range(0, 2) == 0);
          #1;
        end
      end
      n_checks++;
      if (!done_seen) begin n_fail++; $display("FAIL rnd_timeout t%0d got no done exp done", t); end
      else if (kind != 2) begin
        n_checks++;
        if (got !== exp_word) begin n_fail++; $display("FAIL rnd_rdata t%0d kind%0d addr %h got %h exp %h", t, kind, addr, got, exp_word); end
      end
      tick();
      if_req = 0; d_req = 0; d_we = 0;
      rdy = ($urandom_range(0, 3) != 0);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      #1;
      n_checks++;
      if ({if_done, d_done} !== 2'b00) begin n_fail++; $display("FAIL rnd_pulse t%0d got %b exp 00", t, {if_done, d_done}); end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++; $display("FAIL rnd_wr_count t%0d got %0d pending exp 0", t, exp_q.size());
        exp_q.delete();
      end
    end
    rdy = 1; io_buffer_full = 0;
    tick(); tick();
    mon_en = 0;
  endtask

  // Test sequence and report
  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_io_store();
    test_half_load();
    test_rdy_pause();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
